// File: rtl/mcmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcmem_ctrl_pkg
// Description : Shared constants for the multi-cycle memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mcmem_ctrl_pkg;

    // Control-unit state codes as driven on the 'state' input
    localparam logic [2:0] C_SIF  = 3'b000;
    localparam logic [2:0] C_SID  = 3'b001;
    localparam logic [2:0] C_SEXE = 3'b010;
    localparam logic [2:0] C_SMEM = 3'b011;
    localparam logic [2:0] C_SWB  = 3'b100;

    localparam int C_TIMEOUT_DEFAULT = 255;
    localparam int C_WDT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mcmem_wdt.sv
`default_nettype none
// ============================================================================
// Module      : mcmem_wdt
// Description : 8-bit bus wait counter; expire flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mcmem_wdt
    import mcmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [C_WDT_W-1:0] C_LIMIT = C_WDT_W'(TIMEOUT - 1);

    logic [C_WDT_W-1:0] r_count;

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mcmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcmem_ctrl
// Description : Multi-cycle CPU memory-bus controller with IR/MDR and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mcmem_ctrl
    import mcmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  state,
    input  logic        wir,
    input  logic        iord,
    input  logic        wmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        timeout
);

    mem_state_t r_state;
    mem_state_t w_next;
    logic       w_start;
    logic       w_expire;
    logic       w_wdt_clear;
    logic       w_wdt_en;
    logic       r_is_fetch;

    assign w_start     = wir | (iord & (state == C_SMEM));
    assign w_wdt_clear = (r_state == ST_IDLE) & w_start;
    assign w_wdt_en    = (r_state == ST_REQ) & ~bus_ack;

    mcmem_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clock  (clock),
        .resetn (resetn),
        .clear  (w_wdt_clear),
        .enable (w_wdt_en),
        .expire (w_expire)
    );

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_REQ;
                    stall  = 1'b1;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // An ack on the expiry edge still completes the access
                if (bus_ack) begin
                    w_next = ST_DONE;
                end else if (w_expire) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (resetn) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            ir         <= '0;
            mdr        <= '0;
            timeout    <= 1'b0;
            r_is_fetch <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        bus_req    <= 1'b1;
                        bus_we     <= wmem & iord;
                        bus_addr   <= addr;
                        bus_wdata  <= wdata;
                        r_is_fetch <= wir;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (r_is_fetch) begin
                            ir <= bus_rdata;
                        end else if (!bus_we) begin
                            mdr <= bus_rdata;
                        end
                    end else if (w_expire) begin
                        bus_req <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mcmem_ctrl.md
MCMEM_CTRL -- requirements
Module: mcmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255, cycles in REQ without bus_ack before the access is aborted (1..255).
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-high reset, despite the name.
REQ-004 state  in  3  current control-unit state (sif=000, sid=001, sexe=010, smem=011, swb=100).
REQ-005 wir  in  1  instruction-fetch request from the control unit.
REQ-006 iord  in  1  data-access select (1 = data address, 0 = PC).
REQ-007 wmem  in  1  data-write request.
REQ-008 addr  in  32  access address from the datapath.
REQ-009 wdata  in  32  store data from the datapath.
REQ-010 bus_req  out  1  memory-bus request, registered.
REQ-011 bus_we  out  1  bus write enable, registered.
REQ-012 bus_addr  out  32  bus address, registered.
REQ-013 bus_wdata  out  32  bus write data, registered.
REQ-014 bus_ack  in  1  single-cycle bus completion strobe.
REQ-015 bus_rdata  in  32  bus read data, valid when bus_ack=1.
REQ-016 ir  out  32  instruction register.
REQ-017 mdr  out  32  memory data register.
REQ-018 stall  out  1  combinational hold for the control-unit and PC state registers.
REQ-019 timeout  out  1  sticky access-abort flag.

Function
REQ-020 FSM states: IDLE, REQ, DONE; encoding is fixed in the shared package.
REQ-021 start = wir | (iord & state==smem), evaluated only in IDLE.
REQ-022 IDLE with start=1: stall=1; next edge latches addr, wdata and bus_we=wmem&iord into the bus registers, sets bus_req=1, and goes to REQ.
REQ-023 REQ: stall=1, bus_req=1, and the bus registers hold their values.
REQ-024 REQ with bus_ack=1 at an edge: bus_req<=0 and go to DONE; for a fetch (kind latched as wir at start), ir<=bus_rdata; for a load (iord & ~wmem), mdr<=bus_rdata; for a store, ir and mdr are unchanged.
REQ-025 DONE: stall=0 and start is ignored; next edge goes to IDLE. This prevents a re-trigger while the control unit advances its state.
REQ-026 Minimum access with bus_ack in the first REQ cycle: stall high for exactly 2 cycles.
REQ-027 8-bit wait counter: cleared on entry to REQ, incremented on each REQ cycle without bus_ack.
REQ-028 Counter reaches TIMEOUT-1 with no bus_ack: timeout<=1, bus_req<=0, go to IDLE; ir and mdr are unchanged and stall drops the next cycle.
REQ-029 bus_ack on the same edge as timeout expiry: the ack wins and timeout is not set.
REQ-030 bus_ack in IDLE or DONE is ignored with no state change.
REQ-031 timeout stays set until reset.

Reset
REQ-032 resetn=1 forces, asynchronously: FSM=IDLE; bus_req, bus_we and timeout to 0; bus_addr, bus_wdata, ir, mdr and the counter to 0.
REQ-033 Reset asserted mid-access drops bus_req in the same cycle; any later bus_ack is ignored.
REQ-034 While resetn=1, stall is 0.

Structure
REQ-035 Shared package holds the control-unit state constants (sif..swb), the IDLE/REQ/DONE encoding and the TIMEOUT default.
REQ-036 The wait counter is a sub-module, mcmem_wdt, with clear, enable, TIMEOUT parameter and expire output.
REQ-037 All other logic is inline; no memory array is inside this block.

Verification
REQ-038 Fetch: wir=1, addr=0x00000004; ack on the 3rd REQ cycle with rdata=0x8C220008 -> bus_addr=0x4, stall high 4 cycles, ir=0x8C220008, mdr unchanged.
REQ-039 Load: state=smem, iord=1, wmem=0, addr=0x10; immediate ack with rdata=0xDEADBEEF -> mdr=0xDEADBEEF, bus_we=0, stall high 2 cycles.
REQ-040 Store: state=smem, iord=1, wmem=1, wdata=0x12345678 -> bus_we=1, bus_wdata=0x12345678; on ack, ir and mdr unchanged.
REQ-041 No ack, TIMEOUT=4 -> bus_req drops after 4 REQ cycles; timeout=1 and stays set across a subsequent fetch.
REQ-042 resetn pulsed in the 2nd REQ cycle, then ack one cycle later -> bus_req=0 immediately, ir=0, FSM stays IDLE.
